ftf_decoder_33: RTL and testbench



---
 rtl/ftf_decoder_33.sv | 120 ++++++++++++
 tb/tb_ftf_decoder_33.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftf_decoder_33.sv
// Three-stage pipelined decoder from 33-bit FTF code words to binary, using Fibonacci weights.
// A single advance signal moves or holds the whole pipeline; delivered output words are counted.
module ftf_decoder_33 #(
    parameter int DW = 24,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [32:0]   code_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] word_count
);

    // Bit 0 weighs 1 and bit k (k >= 1) weighs F(k+1); only bits lo..hi contribute.
    function automatic logic [DW-1:0] partial_sum(input logic [32:0] code, input int lo, input int hi);
        logic [DW-1:0] f_lo;
        logic [DW-1:0] f_hi;
        logic [DW-1:0] f_nx;
        logic [DW-1:0] w;
        logic [DW-1:0] acc;
        acc  = '0;
        f_lo = DW'(1);
        f_hi = DW'(1);
        for (int k = 0; k < 33; k++) begin
            w = (k == 0) ? DW'(1) : f_hi;
            if (k >= lo && k <= hi && code[k]) begin
                acc = acc + w;
            end
            if (k >= 1) begin
                f_nx = f_lo + f_hi;
                f_lo = f_hi;
                f_hi = f_nx;
            end
        end
        return acc;
    endfunction

    logic          adv;
    logic          vld_p0_q, vld_p0_d;
    logic          vld_p1_q, vld_p1_d;
    logic          vld_p2_q, vld_p2_d;
    logic [DW-1:0] psum0_p0_q, psum0_p0_d;
    logic [DW-1:0] psum1_p0_q, psum1_p0_d;
    logic [DW-1:0] psum2_p0_q, psum2_p0_d;
    logic [DW-1:0] sum01_p1_q, sum01_p1_d;
    logic [DW-1:0] sum2_p1_q, sum2_p1_d;
    logic [DW-1:0] data_p2_q, data_p2_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        adv        = !vld_p2_q || out_ready;
        vld_p0_d   = vld_p0_q;
        vld_p1_d   = vld_p1_q;
        vld_p2_d   = vld_p2_q;
        psum0_p0_d = psum0_p0_q;
        psum1_p0_d = psum1_p0_q;
        psum2_p0_d = psum2_p0_q;
        sum01_p1_d = sum01_p1_q;
        sum2_p1_d  = sum2_p1_q;
        data_p2_d  = data_p2_q;
        count_d    = count_q;
        if (adv) begin
            vld_p0_d = in_valid;
            vld_p1_d = vld_p0_q;
            vld_p2_d = vld_p1_q;
            // Stage 0: three partial sums over bit groups 0-10, 11-21, 22-32
            if (in_valid) begin
                psum0_p0_d = partial_sum(code_in, 0, 10);
                psum1_p0_d = partial_sum(code_in, 11, 21);
                psum2_p0_d = partial_sum(code_in, 22, 32);
            end
            // Stage 1: fold the two lower groups
            if (vld_p0_q) begin
                sum01_p1_d = psum0_p0_q + psum1_p0_q;
                sum2_p1_d  = psum2_p0_q;
            end
            // Stage 2: final sum; data loads only behind a valid word so no X ever reaches it
            if (vld_p1_q) begin
                data_p2_d = sum01_p1_q + sum2_p1_q;
            end
        end
        if (vld_p2_q && out_ready) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            count_q   <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        psum0_p0_q <= psum0_p0_d;
        psum1_p0_q <= psum1_p0_d;
        psum2_p0_q <= psum2_p0_d;
        sum01_p1_q <= sum01_p1_d;
        sum2_p1_q  <= sum2_p1_d;
    end

    assign in_ready   = adv;
    assign data_out   = data_p2_q;
    assign out_valid  = vld_p2_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_ftf_decoder_33.sv
// Scoreboard bench for ftf_decoder_33: expected values queued at acceptance, compared at delivery.
module tb_ftf_decoder_33;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int MAX_VAL = 9227464;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [32:0]   code_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] word_count;

    ftf_decoder_33 #(.DW(DW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .code_in(code_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   bp_en = 1'b0;
    logic rdy_force = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_decode(input logic [32:0] c);
        int unsigned f [0:34];
        int unsigned s;
        f[0] = 0; f[1] = 1; f[2] = 1;
        for (int n = 3; n <= 34; n++) f[n] = f[n-1] + f[n-2];
        s = c[0] ? 1 : 0;
        for (int k = 1; k <= 32; k++) if (c[k]) s += f[k+1];
        return s[DW-1:0];
    endfunction

    // Greedy encoder model: highest weight first, bit 0 takes any remaining 1.
    function automatic logic [32:0] encode(input int unsigned v);
        int unsigned f [0:34];
        int unsigned r;
        logic [32:0] c;
        f[0] = 0; f[1] = 1; f[2] = 1;
        for (int n = 3; n <= 34; n++) f[n] = f[n-1] + f[n-2];
        c = '0;
        r = v;
        for (int k = 32; k >= 1; k--) begin
            if (r >= f[k+1]) begin
                c[k] = 1'b1;
                r -= f[k+1];
            end
        end
        if (r == 1) c[0] = 1'b1;
        return c;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 1) == 1) : rdy_force;
        end
    end

    // Output monitor
    initial begin
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        exp_t          e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                check_eq("in_ready", in_ready, !(out_valid && !out_ready));
                if (prev_stall) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", data_out, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("data", data_out, e.val);
                        if (lat_chk) check_eq("latency", cyc - e.cyc, 3);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = data_out;
            end
        end
    end

    task automatic send(input logic [32:0] c, input logic [DW-1:0] v, output int acc_cyc);
        int waitn;
        waitn   = 0;
        acc_cyc = -1;
        @(posedge clock);
        #1;
        code_in  = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                acc_cyc = cyc;
                sb.push_back('{val: v, cyc: cyc});
                break;
            end
            waitn++;
            if (waitn > 100) begin
                check_eq("accept_timeout", in_ready, 1);
                break;
            end
            @(posedge clock);
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] c;
        int unsigned v;
        int          acc, first_acc, last_acc;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_word_count", word_count, 0);
        check_eq("rst_in_ready", in_ready, 1);

        // Single words with fixed expectations
        send(33'h0,         DW'(0),       acc); idle(); drain(20);
        send(33'h1,         DW'(1),       acc); idle(); drain(20);
        send(33'h4,         DW'(2),       acc); idle(); drain(20);
        send(33'h1_0000_0000, DW'(3524578), acc); idle(); drain(20);
        send(33'h1_8000_0000, DW'(5702887), acc); idle(); drain(20);
        send(33'h1_FFFF_FFFF, DW'(MAX_VAL), acc); idle(); drain(20);
        check_eq("count_singles", word_count, 6);

        // Back-to-back stream
        do_reset();
        first_acc = 0;
        last_acc  = 0;
        for (int i = 0; i < 100; i++) begin
            c = {1'($urandom_range(0, 1)), 32'($urandom)};
            send(c, ref_decode(c), acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
        idle();
        drain(50);
        check_eq("stream_throughput", last_acc - first_acc, 99);
        check_eq("count_stream", word_count, 100);

        // Backpressure
        do_reset();
        lat_chk = 1'b0;
        bp_en   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c = {1'($urandom_range(0, 1)), 32'($urandom)};
            send(c, ref_decode(c), acc);
        end
        idle();
        drain(300);
        bp_en = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("count_bp", word_count, 10);
        lat_chk = 1'b1;

        // Reset with three words stalled in the pipeline
        rdy_force = 1'b0;
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            c = {1'($urandom_range(0, 1)), 32'($urandom)};
            send(c, ref_decode(c), acc);
        end
        do_reset();
        rdy_force = 1'b1;
        repeat (6) @(negedge clock);
        check_eq("post_rst_out_valid", out_valid, 0);
        check_eq("post_rst_count", word_count, 0);
        check_eq("post_rst_in_ready", in_ready, 1);
        send(33'h1_0000_0002, DW'(3524579), acc);
        idle();
        drain(20);
        check_eq("post_rst_count1", word_count, 1);

        // Loopback through the encoder model
        for (int i = 0; i < 1000; i++) begin
            v = $urandom_range(0, MAX_VAL);
            send(encode(v), v[DW-1:0], acc);
        end
        idle();
        drain(50);
        check_eq("count_loop", word_count, 1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
